// File: rtl/iig_window_reader.sv
// Integral-image window reader: scans every WIN x WIN window of a finished IIGBRAM frame and
// emits D - B - C + A per window. Optional abort input enabled by defining IIG_RD_ABORT_EN.
module iig_window_reader #(
  parameter int unsigned IMG_W = 80,
  parameter int unsigned IMG_H = 60,
  parameter int unsigned WIN   = 24,
  parameter int unsigned STEP  = 2,
  parameter int unsigned DW    = 21,
  parameter int unsigned AW    = 13
) (
  input  logic          iClk,
  input  logic          iReset_n,
  input  logic          iStart,
`ifdef IIG_RD_ABORT_EN
  input  logic          iAbort,
`endif
  output logic          oRden_IIGBRAM,
  output logic [AW-1:0] oAddr_IIGBRAM,
  input  logic [DW-1:0] iData_IIGBRAM,
  output logic          oValid,
  input  logic          iReady,
  output logic [6:0]    oWin_x,
  output logic [5:0]    oWin_y,
  output logic [DW-1:0] oWin_sum,
  output logic          oBusy,
  output logic          oDone
);

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdB,
    StRdC,
    StRdD,
    StCap,
    StOut,
    StDone
  } state_e;

  localparam logic [6:0] XLast = 7'(IMG_W - WIN);
  localparam logic [5:0] YLast = 6'(IMG_H - WIN);
  localparam logic [6:0] XStep = 7'(STEP);
  localparam logic [5:0] YStep = 6'(STEP);
  localparam logic [7:0] ColSpan = 8'(WIN - 1);
  localparam logic [6:0] RowSpan = 7'(WIN - 1);

  state_e          r_state, w_state_nxt;
  logic [6:0]      r_x, w_x_nxt;
  logic [5:0]      r_y, w_y_nxt;
  logic            r_rden, r_rd_dly;
  logic [AW-1:0]   r_addr;
  logic            r_valid, r_busy, r_done;
  logic [DW-1:0]   r_a, r_b, r_c, r_sum;
  logic            w_abort;
  logic            w_rd;
  logic [7:0]      w_col;
  logic [6:0]      w_row;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_rdata;

  // Next state and window origin
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_abort     = 1'b0;
`ifdef IIG_RD_ABORT_EN
    w_abort     = iAbort && (r_state != StIdle);
`endif
    unique case (r_state)
      StIdle: if (iStart) w_state_nxt = StRdA;
      StRdA:  w_state_nxt = StRdB;
      StRdB:  w_state_nxt = StRdC;
      StRdC:  w_state_nxt = StRdD;
      StRdD:  w_state_nxt = StCap;
      StCap:  w_state_nxt = StOut;
      StOut: begin
        if (iReady) begin
          if (r_x == XLast && r_y == YLast) begin
            w_state_nxt = StDone;
            w_x_nxt     = '0;
            w_y_nxt     = '0;
          end else begin
            w_state_nxt = StRdA;
            if (r_x + XStep > XLast) begin
              w_x_nxt = '0;
              w_y_nxt = r_y + YStep;
            end else begin
              w_x_nxt = r_x + XStep;
            end
          end
        end
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
    if (w_abort) begin
      w_state_nxt = StIdle;
      w_x_nxt     = '0;
      w_y_nxt     = '0;
    end
  end

  // Corner address for the read state being entered; edge corners are skipped but keep their slot
  always_comb begin
    w_rd  = 1'b0;
    w_col = {1'b0, w_x_nxt} + ColSpan;
    w_row = {1'b0, w_y_nxt} + RowSpan;
    case (w_state_nxt)
      StRdA: begin
        w_rd  = (w_x_nxt != '0) && (w_y_nxt != '0);
        w_col = {1'b0, w_x_nxt} - 8'd1;
        w_row = {1'b0, w_y_nxt} - 7'd1;
      end
      StRdB: begin
        w_rd  = (w_y_nxt != '0);
        w_row = {1'b0, w_y_nxt} - 7'd1;
      end
      StRdC: begin
        w_rd  = (w_x_nxt != '0);
        w_col = {1'b0, w_x_nxt} - 8'd1;
      end
      StRdD:   w_rd = 1'b1;
      default: w_rd = 1'b0;
    endcase
    w_addr = AW'(w_row) * AW'(IMG_W) + AW'(w_col);
  end

  // Skipped corners contribute zero
  assign w_rdata = r_rd_dly ? iData_IIGBRAM : '0;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state  <= StIdle;
      r_x      <= '0;
      r_y      <= '0;
      r_rden   <= 1'b0;
      r_rd_dly <= 1'b0;
      r_addr   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_sum    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_rden   <= w_rd;
      r_rd_dly <= r_rden;
      if (w_rd) r_addr <= w_addr;
      r_valid  <= (w_state_nxt == StOut);
      r_busy   <= (w_state_nxt != StIdle) && (w_state_nxt != StDone);
      r_done   <= (w_state_nxt == StDone);
      case (r_state)
        StRdB:   r_a   <= w_rdata;
        StRdC:   r_b   <= w_rdata;
        StRdD:   r_c   <= w_rdata;
        StCap:   r_sum <= w_rdata - r_b - r_c + r_a;
        default: ;
      endcase
    end
  end

  assign oRden_IIGBRAM = r_rden;
  assign oAddr_IIGBRAM = r_addr;
  assign oValid        = r_valid;
  assign oWin_x        = r_x;
  assign oWin_y        = r_y;
  assign oWin_sum      = r_sum;
  assign oBusy         = r_busy;
  assign oDone         = r_done;

endmodule

// File: tb/tb_iig_window_reader.sv
// Randomized scoreboard bench for iig_window_reader: pixel-level window sums and corner address lists.
module tb_iig_window_reader;

  localparam int IMG_W = 80;
  localparam int IMG_H = 60;
  localparam int WIN   = 24;
  localparam int STEP  = 2;
  localparam int DW    = 21;
  localparam int AW    = 13;
  localparam int NWIN  = ((IMG_W - WIN) / STEP + 1) * ((IMG_H - WIN) / STEP + 1);

  typedef struct {
    int x;
    int y;
    int sum;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          ready = 1'b1;
  logic          rden, valid, busy, done;
  logic [AW-1:0] addr;
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] wsum;
  logic [6:0]    wx;
  logic [5:0]    wy;
`ifdef IIG_RD_ABORT_EN
  logic          abort = 1'b0;
`endif

  always #5 clk = ~clk;

  iig_window_reader u_dut (
    .iClk          (clk),
    .iReset_n      (rst_n),
    .iStart        (start),
`ifdef IIG_RD_ABORT_EN
    .iAbort        (abort),
`endif
    .oRden_IIGBRAM (rden),
    .oAddr_IIGBRAM (addr),
    .iData_IIGBRAM (rdata),
    .oValid        (valid),
    .iReady        (ready),
    .oWin_x        (wx),
    .oWin_y        (wy),
    .oWin_sum      (wsum),
    .oBusy         (busy),
    .oDone         (done)
  );

  // Behavioural BRAM holding the integral image
  logic [DW-1:0] mem [IMG_W*IMG_H];
  always @(posedge clk) if (rden) rdata <= mem[addr];

  int   pix [IMG_H][IMG_W];
  res_t exp_q[$];
  int   addr_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_acc_frame = 0, n_done = 0, frame_rd = 0, first_rd = 0, last_rd = 0;
  int trig_cyc = 0, stall_cnt = 0, stall_mode = 0;
  bit trig_ok = 0, in_win = 0, held = 0, aborted = 0;
  int hx, hy, hs;
  res_t e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic load_image(input bit rnd);
    int ii [IMG_H][IMG_W];
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) begin
        pix[r][c] = rnd ? int'($urandom_range(0, 255)) : 1;
        ii[r][c]  = pix[r][c] + (r > 0 ? ii[r-1][c] : 0) + (c > 0 ? ii[r][c-1] : 0)
                    - ((r > 0 && c > 0) ? ii[r-1][c-1] : 0);
        mem[r*IMG_W + c] = DW'(ii[r][c]);
      end
  endtask

  task automatic push_frame();
    for (int y = 0; y <= IMG_H - WIN; y += STEP)
      for (int x = 0; x <= IMG_W - WIN; x += STEP) begin
        res_t r;
        int   s = 0;
        for (int rr = 0; rr < WIN; rr++)
          for (int cc = 0; cc < WIN; cc++) s += pix[y+rr][x+cc];
        r.x = x; r.y = y; r.sum = s;
        exp_q.push_back(r);
        if (x > 0 && y > 0) addr_q.push_back((y - 1) * IMG_W + x - 1);
        if (y > 0) addr_q.push_back((y - 1) * IMG_W + x + WIN - 1);
        if (x > 0) addr_q.push_back((y + WIN - 1) * IMG_W + x - 1);
        addr_q.push_back((y + WIN - 1) * IMG_W + x + WIN - 1);
      end
  endtask

  task automatic start_frame();
    push_frame();
    @(posedge clk); #1;
    n_acc_frame = 0; frame_rd = 0; stall_cnt = 0; aborted = 0;
    start = 1'b1; trig_cyc = cyc; trig_ok = 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_windows(input int n);
    for (int i = 0; i < 8000 && n_acc_frame < n; i++) @(posedge clk);
    check("reach_window", n_acc_frame >= n, 1);
  endtask

  task automatic run_frame();
    int d0;
    d0 = n_done;
    start_frame();
    for (int i = 0; i < 40000 && n_done == d0; i++) @(posedge clk);
    check("frame_done", n_done - d0, 1);
    repeat (4) @(posedge clk);
    check("done_once", n_done - d0, 1);
    check("frame_windows", n_acc_frame, NWIN);
    check("first_rd_addr", first_rd, 1863);
    check("last_rd_addr", last_rd, 4799);
    check("results_left", exp_q.size(), 0);
    check("addrs_left", addr_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_rden"}, rden, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_x"}, wx, 0);
    check({tag, "_y"}, wy, 0);
    check({tag, "_sum"}, wsum, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // Downstream ready driver
  initial forever begin
    @(posedge clk); #1;
    case (stall_mode)
      1: if (valid && n_acc_frame == 3 && stall_cnt < 10) begin
           ready = 1'b0;
           stall_cnt++;
         end else ready = 1'b1;
      2: ready = ($urandom_range(0, 3) != 0);
      3: ready = (n_acc_frame != 10);
      default: ready = 1'b1;
    endcase
  end

  // Monitor: pops expectations whenever the DUT reads or presents a result
  always @(negedge clk) begin
    if (!rst_n) begin
      in_win = 0; held = 0; trig_ok = 0;
    end else begin
      if (rden) begin
        check("rd_expected", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) check("rd_addr", addr, addr_q.pop_front());
        if (frame_rd == 0) first_rd = addr;
        last_rd = addr;
        frame_rd++;
      end
      if (valid) begin
        if (!in_win) begin
          in_win = 1;
          check("busy_in_window", busy, 1);
          if (trig_ok) check("latency", cyc - trig_cyc, 6);
          trig_ok = 0;
        end
        if (held) begin
          check("hold_x", wx, hx);
          check("hold_y", wy, hy);
          check("hold_sum", wsum, hs);
          check("stall_no_read", rden, 0);
        end
        if (ready) begin
          check("result_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("win_x", wx, e.x);
            check("win_y", wy, e.y);
            check("win_sum", wsum, e.sum);
          end
          in_win = 0; held = 0; n_acc_frame++;
          trig_cyc = cyc; trig_ok = 1;
        end else begin
          held = 1; hx = wx; hy = wy; hs = wsum;
        end
      end else begin
        if (held && !aborted) check("valid_held", valid, 1);
        held = 0;
      end
      if (done) begin
        n_done++;
        check("done_after_last", n_acc_frame, NWIN);
        check("done_busy_low", busy, 0);
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // All-ones image with a 10-cycle stall on the fourth window
    load_image(0);
    stall_mode = 1;
    run_frame();
    check("stall_applied", stall_cnt, 10);

    // Random image, random backpressure
    load_image(1);
    stall_mode = 2;
    run_frame();

    // Stray iStart while busy, then asynchronous reset mid-scan
    stall_mode = 0;
    start_frame();
    wait_windows(5);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_windows(8);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame();

`ifdef IIG_RD_ABORT_EN
    begin
      int d0;
      load_image(1);
      stall_mode = 3;
      start_frame();
      wait_windows(10);
      for (int i = 0; i < 50 && !valid; i++) @(posedge clk);
      #1;
      check("abort_at_out", valid, 1);
      d0 = n_done;
      aborted = 1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      exp_q.delete();
      addr_q.delete();
      check("abort_valid", valid, 0);
      check("abort_busy", busy, 0);
      check("abort_x", wx, 0);
      check("abort_y", wy, 0);
      repeat (10) @(posedge clk);
      check("abort_no_done", n_done - d0, 0);
      check("abort_no_reads", addr_q.size(), 0);
      stall_mode = 0;
      run_frame();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
